// File: rtl/dmem_access_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl
//   MEM-stage data-memory sequencer. It accepts the EX/MEM load/store and runs
//   a req/gnt/rvalid handshake with a multi-cycle data memory. It shifts store
//   data and byte strobes into their lanes, and aligns and extends load data.
//   While the access is outstanding it holds stall high, which freezes the
//   pipeline up to and including EX/MEM.
//
//   Optional feature macro: DMEM_TIMEOUT_EN
//     defined   : an access stuck in REQ/WAIT for TIMEOUT cycles completes with
//                 bus_err=1
//     undefined : no timeout counter, and bus_err is tied to 0
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   op_valid/op_we      MEM-stage op is a load/store, and 1 = store
//   op_funct3           RV32I width/sign code
//   op_addr/op_wdata    effective address and raw store data
//   ext_stall           pipeline frozen by another source (DONE is held)
//   dm_req/dm_we        memory request strobe and write flag
//   dm_addr             word-aligned request address
//   dm_wstrb/dm_wdata   byte enables and lane-shifted store data
//   dm_gnt              memory accepts the request
//   dm_rvalid/dm_rdata  read response
//   stall               freeze pipeline registers
//   ld_data             aligned/extended load result
//   done                access complete
//   misalign_exc        misaligned or illegal-funct3 access
//   bus_err             access aborted by timeout
// ----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_we,
    input  logic [2:0]  op_funct3,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic        ext_stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        done,
    output logic        misalign_exc,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  f3_q;          // funct3 of the accepted op, used for load formatting
    logic [1:0]  a_q;           // byte offset of the accepted op
    logic        legal_op;
    logic [3:0]  strb_fmt;
    logic [31:0] wdata_fmt;
    logic [31:0] rdata_shift;
    logic [31:0] rdata_fmt;
    logic        rd_capture;
    logic        timeout_hit;

    // ------------------------------------------------------------------
    // Decode of the incoming op: legality, store lanes
    // ------------------------------------------------------------------
    always_comb begin
        legal_op = 1'b0;
        case (op_funct3)
            3'b000:  legal_op = 1'b1;
            3'b001:  legal_op = ~op_addr[0];
            3'b010:  legal_op = (op_addr[1:0] == 2'b00);
            3'b100:  legal_op = ~op_we;
            3'b101:  legal_op = ~op_we & ~op_addr[0];
            default: legal_op = 1'b0;
        endcase
    end

    always_comb begin
        strb_fmt = 4'b1111;
        case (op_funct3[1:0])
            2'b00:   strb_fmt = 4'b0001 << op_addr[1:0];
            2'b01:   strb_fmt = 4'b0011 << op_addr[1:0];
            default: strb_fmt = 4'b1111;
        endcase
    end

    assign wdata_fmt = op_wdata << {op_addr[1:0], 3'b000};

    // ------------------------------------------------------------------
    // Load formatting from the registered funct3 and offset
    // ------------------------------------------------------------------
    assign rdata_shift = dm_rdata >> {a_q, 3'b000};

    always_comb begin
        rdata_fmt = '0;
        case (f3_q)
            3'b000:  rdata_fmt = {{24{rdata_shift[7]}},  rdata_shift[7:0]};
            3'b001:  rdata_fmt = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b010:  rdata_fmt = rdata_shift;
            3'b100:  rdata_fmt = {24'b0, rdata_shift[7:0]};
            3'b101:  rdata_fmt = {16'b0, rdata_shift[15:0]};
            default: rdata_fmt = '0;
        endcase
    end

    // A response is accepted only for a load, either together with the grant
    // or afterwards in WAIT. rvalid in any other state is ignored.
    assign rd_capture = ~dm_we & dm_rvalid &
                        (((state == S_REQ) & dm_gnt) | (state == S_WAIT));

    // ------------------------------------------------------------------
    // Optional timeout
    // ------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             bus_err_q;

    // The count holds the number of REQ/WAIT cycles already spent. The final
    // allowed cycle is the one where it equals TIMEOUT-1.
    assign timeout_hit = (((state == S_REQ) & ~dm_gnt) | ((state == S_WAIT) & ~dm_rvalid)) &
                         (tmo_cnt >= CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == S_IDLE) begin
            tmo_cnt <= '0;
        end else if ((state == S_REQ) || (state == S_WAIT)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
        end else if ((state == S_DONE) && !ext_stall) begin
            bus_err_q <= 1'b0;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    state_nxt = legal_op ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (dm_gnt) begin
                    state_nxt = (dm_we || dm_rvalid) ? S_DONE : S_WAIT;
                end else if (timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_WAIT: begin
                if (dm_rvalid || timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!ext_stall) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        dm_req = 1'b0;
        stall  = 1'b0;
        done   = 1'b0;
        case (state)
            S_IDLE: stall = op_valid;
            S_REQ: begin
                dm_req = 1'b1;
                stall  = 1'b1;
            end
            S_WAIT: stall = 1'b1;
            S_DONE: done  = 1'b1;
            default: ;
        endcase
        // While rst is high, op_valid must not freeze the pipeline.
        if (rst) begin
            stall = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Request registers and completion status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_wstrb     <= '0;
            dm_wdata     <= '0;
            f3_q         <= '0;
            a_q          <= '0;
            ld_data      <= '0;
            misalign_exc <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        ld_data <= '0;
                        if (legal_op) begin
                            dm_we    <= op_we;
                            dm_addr  <= {op_addr[31:2], 2'b00};
                            dm_wstrb <= op_we ? strb_fmt  : '0;
                            dm_wdata <= op_we ? wdata_fmt : '0;
                            f3_q     <= op_funct3;
                            a_q      <= op_addr[1:0];
                        end else begin
                            misalign_exc <= 1'b1;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    if (rd_capture) begin
                        ld_data <= rdata_fmt;
                    end else if (timeout_hit) begin
                        ld_data <= '0;
                    end
                end
                S_DONE: begin
                    if (!ext_stall) begin
                        misalign_exc <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
